// File: rtl/sd_arbiter.sv
// Two-requester arbiter for a single SD controller: grants whole-sector transfers
// round-robin and sequences the controller's per-byte read/write handshakes.
module sd_arbiter #(
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_address,
  output logic [1:0]  req_ack,
  output logic [7:0]  rd_data,
  output logic [1:0]  rd_valid,
  input  logic [15:0] wr_data,
  output logic [1:0]  wr_take,
  output logic [1:0]  done,
  output logic [1:0]  error,
  input  logic        sd_ready,
  output logic        sd_read,
  output logic        sd_write,
  output logic [31:0] sd_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic        sd_read_ack,
  output logic [7:0]  sd_din,
  input  logic        sd_write_ready
);

  localparam int CW = $clog2(SECTOR_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD_ACK  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] WR_HOLD = 3'd5;
  localparam logic [2:0] FINISH  = 3'd6;

  logic [2:0]    state;
  logic          owner;
  logic          dir;
  logic          last_grant;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo;

  logic          pick;
  logic          pick_write;
  logic          event_seen;
  logic          tmo_hit;
  logic          sector_end;
  logic [1:0]    owner_sel;

  always_comb begin
    pick       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    pick_write = pick ? req_write[1] : req_write[0];
    tmo_hit    = (tmo == TW'(TIMEOUT_CYCLES - 1));
    sector_end = (count == CW'(SECTOR_BYTES));
    owner_sel  = {owner, ~owner};
    // Every wait state leaves as soon as its event is seen, so this also
    // marks the cycles on which the timeout counter restarts.
    event_seen = 1'b1;
    case (state)
      ISSUE:   event_seen = !sd_ready;
      RD_WAIT: event_seen = sd_byte_available;
      RD_ACK:  event_seen = !sd_byte_available;
      WR_WAIT: event_seen = sd_write_ready;
      WR_HOLD: event_seen = !sd_write_ready;
      FINISH:  event_seen = sd_ready;
      default: event_seen = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      dir         <= 1'b0;
      last_grant  <= 1'b1;
      count       <= '0;
      tmo         <= '0;
      req_ack     <= '0;
      rd_data     <= '0;
      rd_valid    <= '0;
      wr_take     <= '0;
      done        <= '0;
      error       <= '0;
      sd_read     <= 1'b0;
      sd_write    <= 1'b0;
      sd_address  <= '0;
      sd_read_ack <= 1'b0;
      sd_din      <= '0;
    end else begin
      req_ack  <= '0;
      rd_valid <= '0;
      wr_take  <= '0;
      done     <= '0;
      error    <= '0;
      tmo      <= (state != IDLE && !event_seen) ? tmo + TW'(1) : '0;

      if (state != IDLE && !event_seen && tmo_hit) begin
        sd_read     <= 1'b0;
        sd_write    <= 1'b0;
        sd_read_ack <= 1'b0;
        error       <= owner_sel;
        count       <= '0;
        tmo         <= '0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (sd_ready && (|req_valid)) begin
              owner      <= pick;
              dir        <= pick_write;
              last_grant <= pick;
              sd_address <= pick ? req_address[63:32] : req_address[31:0];
              req_ack    <= {pick, ~pick};
              sd_read    <= !pick_write;
              sd_write   <= pick_write;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            if (event_seen) begin
              sd_read  <= 1'b0;
              sd_write <= 1'b0;
              state    <= dir ? WR_WAIT : RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (event_seen) begin
              rd_data     <= sd_dout;
              rd_valid    <= owner_sel;
              sd_read_ack <= 1'b1;
              count       <= count + CW'(1);
              state       <= RD_ACK;
            end
          end
          RD_ACK: begin
            if (event_seen) begin
              sd_read_ack <= 1'b0;
              state       <= sector_end ? FINISH : RD_WAIT;
            end
          end
          WR_WAIT: begin
            if (event_seen) begin
              sd_din  <= owner ? wr_data[15:8] : wr_data[7:0];
              wr_take <= owner_sel;
              count   <= count + CW'(1);
              state   <= WR_HOLD;
            end
          end
          WR_HOLD: begin
            if (event_seen) begin
              state <= sector_end ? FINISH : WR_WAIT;
            end
          end
          FINISH: begin
            if (event_seen) begin
              done  <= owner_sel;
              count <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_arbiter.sv
// Scoreboard bench for sd_arbiter: a behavioural SD controller and requesters drive
// the DUT; expected output events are queued by the stimulus and checked by a monitor.
module tb_sd_arbiter;

  localparam int SECT = 512;
  localparam int TMO  = 64;

  localparam logic [2:0] K_ACK  = 3'd1;
  localparam logic [2:0] K_RD   = 3'd2;
  localparam logic [2:0] K_TAKE = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;
  localparam logic [2:0] K_ERR  = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic       idx;
    logic [7:0] data;
  } evt_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_address;
  logic [1:0]  req_ack;
  logic [7:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [15:0] wr_data;
  logic [1:0]  wr_take;
  logic [1:0]  done;
  logic [1:0]  error;
  logic        sd_ready;
  logic        sd_read;
  logic        sd_write;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic        sd_read_ack;
  logic [7:0]  sd_din;
  logic        sd_write_ready;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  evt_t q[$];

  int   park_at = -1;
  int   park_mode = 0;
  int   stall_cyc = 0;
  logic parked = 1'b0;
  logic model_abort = 1'b0;
  logic force_busy = 1'b0;
  logic [7:0] cap [SECT];
  int   cap_n = 0;

  sd_arbiter #(.SECTOR_BYTES(SECT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_ack(req_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_data(wr_data), .wr_take(wr_take), .done(done), .error(error),
    .sd_ready(sd_ready), .sd_read(sd_read), .sd_write(sd_write),
    .sd_address(sd_address), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available), .sd_read_ack(sd_read_ack),
    .sd_din(sd_din), .sd_write_ready(sd_write_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic evt_t mk(input logic [2:0] k, input int r, input logic [7:0] d);
    evt_t e;
    e.kind = k;
    e.idx  = (r != 0);
    e.data = d;
    return e;
  endfunction

  task automatic expect_evt(input evt_t a);
    evt_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected actual=%0h required=none", a);
    end else begin
      e = q.pop_front();
      if (e !== a) begin
        failures++;
        $display("FAIL event_order actual=%0h required=%0h", a, e);
      end
    end
  endtask

  task automatic push_sector(input logic [2:0] k, input int r, input int n, input logic with_done);
    q.push_back(mk(K_ACK, r, 8'h00));
    for (int b = 0; b < n; b++) q.push_back(mk(k, r, (k == K_RD) ? 8'(b) : 8'h00));
    if (with_done) q.push_back(mk(K_DONE, r, 8'h00));
  endtask

  // kind 0 waits for req_ack[r], kind 1 for done[r]
  task automatic wait_pulse(input int kind, input int r, input int budget, input string name);
    int g = 0;
    while (!((kind == 0) ? req_ack[r] : done[r]) && g < budget) begin
      @(negedge clock);
      g++;
    end
    chk(name, 64'(((kind == 0) ? req_ack[r] : done[r])), 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int g = 0;
    while (q.size() != 0 && g < budget) begin
      @(negedge clock);
      g++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- SD controller model ----------------
  task automatic park();
    int g = 0;
    parked = 1'b1;
    while (error == 2'b00 && !model_abort && g < 500) begin
      @(negedge clock);
      g++;
    end
    sd_byte_available = 1'b0;
    sd_ready = 1'b1;
    parked = 1'b0;
  endtask

  task automatic serve_read();
    int g;
    sd_ready = 1'b0;
    for (int b = 0; b < SECT; b++) begin
      if (b == park_at && park_mode == 0) begin
        stall_cyc = cyc;
        park();
        return;
      end
      sd_dout = 8'(b);
      sd_byte_available = 1'b1;
      g = 0;
      do begin @(negedge clock); g++; end while (!sd_read_ack && !model_abort && g < 200);
      if (b == park_at && park_mode == 1) begin
        park();
        return;
      end
      if (!sd_read_ack) begin
        sd_byte_available = 1'b0;
        sd_ready = 1'b1;
        return;
      end
      sd_byte_available = 1'b0;
      g = 0;
      do begin @(negedge clock); g++; end while (sd_read_ack && !model_abort && g < 200);
    end
    sd_ready = 1'b1;
  endtask

  task automatic serve_write();
    int g;
    sd_ready = 1'b0;
    cap_n = 0;
    for (int b = 0; b < SECT; b++) begin
      sd_write_ready = 1'b1;
      g = 0;
      do begin @(negedge clock); g++; end while (wr_take == 2'b00 && g < 200);
      sd_write_ready = 1'b0;
      if (wr_take == 2'b00) break;
      cap[b] = sd_din;
      cap_n++;
      @(negedge clock);
    end
    sd_ready = 1'b1;
  endtask

  initial begin : sd_model
    sd_ready = 1'b1;
    sd_dout = '0;
    sd_byte_available = 1'b0;
    sd_write_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (sd_ready && sd_read) serve_read();
      else if (sd_ready && sd_write) serve_write();
      sd_ready = !force_busy;
    end
  end

  // Requester 1 write source: presents a byte counter advanced by wr_take[1].
  initial begin : wr_src
    int wcnt;
    wcnt = 0;
    wr_data = {8'h00, 8'hA5};
    forever begin
      @(negedge clock);
      if (wr_take[1]) wcnt++;
      wr_data = {8'(wcnt), 8'hA5};
    end
  end

  // ---------------- Monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (|{req_ack, rd_valid, wr_take, done, error}) begin
        checks++;
        if (req_ack == 2'b11 || rd_valid == 2'b11 || wr_take == 2'b11 ||
            done == 2'b11 || error == 2'b11) begin
          failures++;
          $display("FAIL onehot actual=%0h required=single_bit", {req_ack, rd_valid, wr_take, done, error});
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (req_ack[r])  expect_evt(mk(K_ACK, r, 8'h00));
        if (rd_valid[r]) expect_evt(mk(K_RD, r, rd_data));
        if (wr_take[r])  expect_evt(mk(K_TAKE, r, 8'h00));
        if (done[r])     expect_evt(mk(K_DONE, r, 8'h00));
        if (error[r]) begin
          expect_evt(mk(K_ERR, r, 8'h00));
          chk("tmo_cycles", 64'(cyc - stall_cyc), 64'(TMO));
          chk("tmo_strobes", 64'({sd_read, sd_write, sd_read_ack}), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  initial begin : stim
    int bad;
    reset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_address = '0;
    repeat (3) @(negedge clock);
    chk("rst_pulses", 64'({req_ack, rd_valid, wr_take, done, error}), 64'd0);
    chk("rst_strobes", 64'({sd_read, sd_write, sd_read_ack}), 64'd0);
    chk("rst_regs", 64'({sd_address, sd_din, rd_data}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single read sector by requester 0
    push_sector(K_RD, 0, SECT, 1'b1);
    req_write = 2'b00;
    req_address = {32'h0000_0000, 32'h0000_0100};
    req_valid = 2'b01;
    @(negedge clock);
    chk("ack_latency", 64'(req_ack), 64'd1);
    wait_pulse(0, 0, 10, "read_ack");
    req_valid = 2'b00;
    chk("read_strobe", 64'({sd_read, sd_write}), 64'b10);
    chk("read_address", 64'(sd_address), 64'h100);
    wait_drain(5000, "read_drain");

    // Tie arbitration from reset: 0,1,0,1
    do_reset();
    push_sector(K_RD, 0, SECT, 1'b1);
    push_sector(K_RD, 1, SECT, 1'b1);
    push_sector(K_RD, 0, SECT, 1'b1);
    push_sector(K_RD, 1, SECT, 1'b1);
    req_address = {32'h0000_0200, 32'h0000_0100};
    req_valid = 2'b11;
    wait_pulse(0, 0, 10, "tie_ack0a");
    req_valid[0] = 1'b0;
    wait_pulse(1, 0, 5000, "tie_done0a");
    req_valid[0] = 1'b1;
    wait_pulse(0, 1, 10, "tie_ack1a");
    req_valid[1] = 1'b0;
    chk("tie_address1", 64'(sd_address), 64'h200);
    wait_pulse(1, 1, 5000, "tie_done1a");
    req_valid[1] = 1'b1;
    wait_pulse(0, 0, 10, "tie_ack0b");
    req_valid[0] = 1'b0;
    wait_pulse(1, 0, 5000, "tie_done0b");
    wait_pulse(0, 1, 10, "tie_ack1b");
    req_valid[1] = 1'b0;
    wait_drain(5000, "tie_drain");

    // Write sector by requester 1
    push_sector(K_TAKE, 1, SECT, 1'b1);
    req_write = 2'b10;
    req_address = {32'h0000_0300, 32'h0000_0000};
    req_valid = 2'b10;
    wait_pulse(0, 1, 10, "write_ack");
    req_valid = 2'b00;
    chk("write_strobe", 64'({sd_read, sd_write}), 64'b01);
    chk("write_address", 64'(sd_address), 64'h300);
    wait_drain(5000, "write_drain");
    chk("write_count", 64'(cap_n), 64'(SECT));
    bad = 0;
    for (int b = 0; b < SECT; b++) if (cap[b] !== 8'(b)) bad++;
    chk("write_bytes_bad", 64'(bad), 64'd0);
    req_write = 2'b00;

    // Controller busy: no grant until sd_ready rises
    force_busy = 1'b1;
    repeat (2) @(negedge clock);
    req_address = {32'h0000_0000, 32'h0000_0400};
    req_valid = 2'b01;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (req_ack != 2'b00) bad++;
    end
    chk("busy_no_ack", 64'(bad), 64'd0);
    push_sector(K_RD, 0, SECT, 1'b1);
    force_busy = 1'b0;
    wait_pulse(0, 0, 10, "busy_ack");
    req_valid = 2'b00;
    wait_drain(5000, "busy_drain");

    // Timeout after 10 bytes, pending requester 1 served next
    park_mode = 0;
    park_at = 10;
    push_sector(K_RD, 0, 10, 1'b0);
    q.push_back(mk(K_ERR, 0, 8'h00));
    push_sector(K_RD, 1, SECT, 1'b1);
    req_address = {32'h0000_0600, 32'h0000_0500};
    req_valid = 2'b01;
    wait_pulse(0, 0, 10, "tmo_ack0");
    req_valid = 2'b10;
    wait_pulse(0, 1, 500, "tmo_ack1");
    req_valid = 2'b00;
    park_at = -1;
    chk("tmo_next_address", 64'(sd_address), 64'h600);
    wait_drain(5000, "tmo_drain");

    // Reset during byte 200 of a read
    park_mode = 1;
    park_at = 200;
    push_sector(K_RD, 0, 201, 1'b0);
    req_address = {32'h0000_0000, 32'h0000_0700};
    req_valid = 2'b01;
    wait_pulse(0, 0, 10, "mid_ack");
    req_valid = 2'b00;
    bad = 0;
    while (!parked && bad < 2000) begin
      @(negedge clock);
      bad++;
    end
    chk("mid_parked", 64'(parked), 64'd1);
    chk("mid_pre_ack", 64'(sd_read_ack), 64'd1);
    reset = 1'b1;
    model_abort = 1'b1;
    @(negedge clock);
    chk("mid_strobes", 64'({sd_read, sd_write, sd_read_ack}), 64'd0);
    chk("mid_pulses", 64'({done, error}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    while (parked && bad < 50) begin
      @(negedge clock);
      bad++;
    end
    model_abort = 1'b0;
    park_at = -1;
    chk("mid_events_left", 64'(q.size()), 64'd0);
    push_sector(K_RD, 0, SECT, 1'b1);
    req_valid = 2'b01;
    wait_pulse(0, 0, 10, "fresh_ack");
    req_valid = 2'b00;
    chk("fresh_address", 64'(sd_address), 64'h700);
    wait_drain(5000, "fresh_drain");

    repeat (5) @(negedge clock);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
